// File: rtl/mem_port_arbiter.sv
// Arbitrates one unified memory port between the core and the loader/debug port, one access at a time.
// Build option MEM_ARB_ROUND_ROBIN_EN: ties alternate between requesters instead of always going to the loader.
module mem_port_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_ack,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ldr_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner_ldr,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        lat_q, lat_d;
    logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
    logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;
    logic              pick_ldr;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_ldr_q, last_ldr_d;

    // last_ldr_q resets to 1 so the core takes the first tie.
    assign pick_ldr = ldr_req && (!core_req || !last_ldr_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_ldr_q <= 1'b1;
        else     last_ldr_q <= last_ldr_d;
    end

    always_comb begin
        last_ldr_d = last_ldr_q;
        if (state_q == S_RESP) last_ldr_d = owner_q;
    end
`else
    assign pick_ldr = ldr_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            lat_q        <= '0;
            core_rdata_q <= '0;
            ldr_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            lat_q        <= lat_d;
            core_rdata_q <= core_rdata_d;
            ldr_rdata_q  <= ldr_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        lat_d        = lat_q;
        core_rdata_d = core_rdata_q;
        ldr_rdata_d  = ldr_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (core_req || ldr_req) begin
                    owner_d = pick_ldr;
                    we_d    = pick_ldr ? ldr_we    : core_we;
                    addr_d  = pick_ldr ? ldr_addr  : core_addr;
                    wdata_d = pick_ldr ? ldr_wdata : core_wdata;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                lat_d   = LAT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lat_q == 3'd0) begin
                    // Writes leave both read-data registers untouched.
                    if (!we_q) begin
                        if (owner_q) ldr_rdata_d  = mem_rdata;
                        else         core_rdata_d = mem_rdata;
                    end
                    state_d = S_RESP;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign owner_ldr  = busy && owner_q;
    assign mem_en     = (state_q == S_ACCESS);
    assign mem_we     = mem_en && we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign core_ack   = (state_q == S_RESP) && !owner_q;
    assign ldr_ack    = (state_q == S_RESP) && owner_q;
    assign core_rdata = core_rdata_q;
    assign ldr_rdata  = ldr_rdata_q;

endmodule
